// File: rtl/ramen_shop.sv
// Ramen stall order controller: checks stock against a fixed recipe table for
// each two-beat order, answers success/fail, and reports revenue and per-type
// sales when the selling session closes.
module ramen_shop (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic        selling,
   input  logic [1:0]  ramen_type,
   input  logic        portion,
   output logic        out_valid_order,
   output logic        success,
   output logic        out_valid_tot,
   output logic [14:0] total_gain,
   output logic [27:0] sold_num
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_ORDER,
      GET_PORTION,
      RESPOND,
      REPORT
   } state_t;

   // One field per ingredient; used both for stock on hand and for a recipe's needs.
   typedef struct packed {
      logic [15:0] noodle;
      logic [15:0] broth;
      logic [15:0] tonkotsu;
      logic [15:0] soy;
      logic [15:0] miso;
   } stock_t;

   localparam stock_t INIT_STOCK = '{
      noodle:   16'd12000,
      broth:    16'd41000,
      tonkotsu: 16'd9000,
      soy:      16'd1000,
      miso:     16'd1000
   };

   // Ingredient needs for one bowl of the given type and size.
   function automatic stock_t recipe(input logic [1:0] kind, input logic big);
      stock_t r;
      r        = '0;
      r.noodle = big ? 16'd150 : 16'd100;
      case (kind)
         2'd0: begin
            r.broth    = big ? 16'd500 : 16'd300;
            r.tonkotsu = big ? 16'd200 : 16'd150;
         end
         2'd1: begin
            r.broth    = big ? 16'd500 : 16'd300;
            r.tonkotsu = big ? 16'd150 : 16'd100;
            r.soy      = big ? 16'd50  : 16'd30;
         end
         2'd2: begin
            r.broth = big ? 16'd650 : 16'd400;
            r.miso  = big ? 16'd50  : 16'd30;
         end
         default: begin
            r.broth    = big ? 16'd500 : 16'd300;
            r.tonkotsu = big ? 16'd100 : 16'd70;
            r.soy      = big ? 16'd25  : 16'd15;
            r.miso     = big ? 16'd25  : 16'd15;
         end
      endcase
      return r;
   endfunction

   // Bowl price, the same for either portion size.
   function automatic logic [14:0] price(input logic [1:0] kind);
      return kind[0] ? 15'd250 : 15'd200;
   endfunction

   state_t          state, next_state;
   logic            selling_q;
   logic [1:0]      type_q;
   stock_t          stock_q;
   logic [14:0]     gain_q;
   logic [3:0][6:0] count_q;   // indexed by ramen type

   stock_t          need;
   logic            enough;
   logic            session_start;

   assign session_start = selling & ~selling_q;

   // Stock check for the order in GET_PORTION: every ingredient must cover its need.
   always_comb begin
      need   = recipe(type_q, portion);
      enough = (stock_q.noodle   >= need.noodle)   &&
               (stock_q.broth    >= need.broth)    &&
               (stock_q.tonkotsu >= need.tonkotsu) &&
               (stock_q.soy      >= need.soy)      &&
               (stock_q.miso     >= need.miso);
   end

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // register samples values from before the clock edge.
      if (!rst_n) state <= IDLE;
      else        state <= next_state;
   end

   // Next-state logic; selling is only looked at while waiting for an order.
   always_comb begin
      // NOTE: the default assignment up front keeps this block free of latches
      // on paths that do not change state.
      next_state = state;
      case (state)
         IDLE:        if (session_start) next_state = WAIT_ORDER;
         WAIT_ORDER: begin
            if (!selling)      next_state = REPORT;
            else if (in_valid) next_state = GET_PORTION;
         end
         GET_PORTION: next_state = RESPOND;
         RESPOND:     next_state = WAIT_ORDER;
         REPORT:      next_state = IDLE;
         default:     next_state = IDLE;
      endcase
   end

   // Datapath: order capture, stock/gain/count bookkeeping and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         // NOTE: stock is loaded with its starting amounts by reset rather than
         // cleared, so an aborted session leaves a ready-to-sell stall.
         stock_q         <= INIT_STOCK;
         selling_q       <= 1'b0;
         type_q          <= '0;
         gain_q          <= '0;
         count_q         <= '0;
         out_valid_order <= 1'b0;
         success         <= 1'b0;
         out_valid_tot   <= 1'b0;
         total_gain      <= '0;
         sold_num        <= '0;
      end else begin
         selling_q       <= selling;
         // Outputs are single-cycle pulses and read zero whenever not valid.
         out_valid_order <= 1'b0;
         success         <= 1'b0;
         out_valid_tot   <= 1'b0;
         total_gain      <= '0;
         sold_num        <= '0;
         case (state)
            IDLE: begin
               if (session_start) begin
                  stock_q <= INIT_STOCK;
                  gain_q  <= '0;
                  count_q <= '0;
               end
            end
            WAIT_ORDER: begin
               if (!selling) begin
                  out_valid_tot <= 1'b1;
                  total_gain    <= gain_q;
                  sold_num      <= {count_q[0], count_q[1], count_q[2], count_q[3]};
               end else if (in_valid) begin
                  type_q <= ramen_type;
               end
            end
            GET_PORTION: begin
               out_valid_order <= 1'b1;
               success         <= enough;
               if (enough) begin
                  stock_q.noodle   <= stock_q.noodle   - need.noodle;
                  stock_q.broth    <= stock_q.broth    - need.broth;
                  stock_q.tonkotsu <= stock_q.tonkotsu - need.tonkotsu;
                  stock_q.soy      <= stock_q.soy      - need.soy;
                  stock_q.miso     <= stock_q.miso     - need.miso;
                  gain_q           <= gain_q + price(type_q);
                  count_q[type_q]  <= count_q[type_q] + 7'd1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ramen_shop.sv
// Directed bench for ramen_shop: hand-computed order results and session reports.
module tb_ramen_shop;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid;
   logic        selling;
   logic [1:0]  ramen_type;
   logic        portion;
   logic        out_valid_order;
   logic        success;
   logic        out_valid_tot;
   logic [14:0] total_gain;
   logic [27:0] sold_num;

   int n_cmp = 0;
   int n_bad = 0;

   ramen_shop dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .in_valid        (in_valid),
      .selling         (selling),
      .ramen_type      (ramen_type),
      .portion         (portion),
      .out_valid_order (out_valid_order),
      .success         (success),
      .out_valid_tot   (out_valid_tot),
      .total_gain      (total_gain),
      .sold_num        (sold_num)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_quiet(input string tag);
      check({tag, " ovo"},  out_valid_order, 0);
      check({tag, " succ"}, success,         0);
      check({tag, " ovt"},  out_valid_tot,   0);
      check({tag, " gain"}, total_gain,      0);
      check({tag, " sold"}, sold_num,        0);
   endtask

   task automatic open_session();
      @(negedge clk) selling = 1'b1;
   endtask

   // Two-beat order; the response is sampled two cycles after beat 1.
   task automatic order(input logic [1:0] kind, input logic big, input logic exp_ok);
      @(negedge clk);
      in_valid   = 1'b1;
      ramen_type = kind;
      @(negedge clk);
      portion = big;
      check("early ovo", out_valid_order, 0);
      @(negedge clk);
      in_valid = 1'b0;
      check("order ovo", out_valid_order, 1);
      check("order success", success, exp_ok);
   endtask

   task automatic close_session(input logic [14:0] exp_gain, input logic [27:0] exp_sold);
      @(negedge clk) selling = 1'b0;
      @(negedge clk);
      check("tot valid", out_valid_tot, 1);
      check("tot gain", total_gain, exp_gain);
      check("tot sold", sold_num, exp_sold);
      @(negedge clk);
      check_quiet("after report");
   endtask

   initial begin
      rst_n      = 1'b0;
      in_valid   = 1'b0;
      selling    = 1'b0;
      ramen_type = 2'd0;
      portion    = 1'b0;
      repeat (2) @(negedge clk);
      check_quiet("reset");
      rst_n = 1'b1;

      // Orders outside a session produce no response.
      order_outside();

      // Single small TONKOTSU.
      open_session();
      order(2'd0, 1'b0, 1'b1);
      close_session(15'd200, 28'h0200000);

      // Soy runs out after 20 big TONKOTSU_SOY.
      open_session();
      for (int i = 0; i < 21; i++) order(2'd1, 1'b1, i < 20);
      close_session(15'd5000, 28'h0050000);

      // Tonkotsu soup runs out after 60 small TONKOTSU.
      open_session();
      for (int i = 0; i < 61; i++) order(2'd0, 1'b0, i < 60);
      close_session(15'd12000, 28'h7800000);

      // One of each type, then a fresh session must see full miso stock again.
      open_session();
      for (int i = 0; i < 4; i++) order(i[1:0], 1'b0, 1'b1);
      close_session(15'd900, 28'h0204081);
      open_session();
      for (int i = 0; i < 20; i++) order(2'd2, 1'b1, 1'b1);
      close_session(15'd4000, 28'h0000A00);

      // Empty session.
      open_session();
      repeat (4) @(negedge clk);
      close_session(15'd0, 28'h0);

      // Reset between beat 1 and beat 2 aborts the order.
      open_session();
      @(negedge clk);
      in_valid   = 1'b1;
      ramen_type = 2'd1;
      @(negedge clk);
      rst_n    = 1'b0;
      in_valid = 1'b0;
      selling  = 1'b0;
      #1 check_quiet("abort");
      repeat (3) begin
         @(negedge clk);
         check("abort no ovo", out_valid_order, 0);
      end
      rst_n = 1'b1;
      open_session();
      order(2'd1, 1'b1, 1'b1);
      close_session(15'd250, 28'h0004000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   task automatic order_outside();
      @(negedge clk);
      in_valid = 1'b1;
      @(negedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      check("idle ovo", out_valid_order, 0);
      @(negedge clk);
      check("idle ovo late", out_valid_order, 0);
   endtask

endmodule
